// File: rtl/id_ex_register_pkg.sv
// Shared decode/execute constants: datapath widths, the NOP ALU code and immediate extension types.
`ifndef ID_EX_REGISTER_PKG_SV
`define ID_EX_REGISTER_PKG_SV
package id_ex_register_pkg;
   localparam int DATA_WIDTH     = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int ALU_OP_WIDTH   = 4;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOP = '0;

   typedef enum logic [1:0] {
      EXT_ZERO = 2'b00,
      EXT_SIGN = 2'b01
   } ext_type_e;
endpackage
`endif

// File: rtl/id_ex_register_load_use_detector.sv
// Load-use hazard detect: a load in EX whose rt feeds a source of the valid ID instruction.
// Purely combinational, zero latency; register $0 never counts as a dependency.
module load_use_detector #(
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      ex_valid,
   input  logic                      ex_mem_read,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
   input  logic                      id_valid,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs,
   input  logic [REG_ADDR_WIDTH-1:0] id_rt,
   input  logic                      id_uses_rs,
   input  logic                      id_uses_rt,
   output logic                      hazard
);
   logic rs_match;
   logic rt_match;

   assign rs_match = id_uses_rs && (id_rs == ex_rt);
   assign rt_match = id_uses_rt && (id_rt == ex_rt);
   assign hazard   = ex_valid && ex_mem_read && (ex_rt != '0) && (rs_match || rt_match) && id_valid;
endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register, 1-cycle latency; flush > ex_stall (hold) > load-use bubble > capture.
// Drives load_use_stall upstream to freeze PC and IF/ID while a hazard bubble is inserted.
module id_ex_register #(
   parameter int DATA_WIDTH     = id_ex_register_pkg::DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = id_ex_register_pkg::REG_ADDR_WIDTH,
   parameter int ALU_OP_WIDTH   = id_ex_register_pkg::ALU_OP_WIDTH,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic                      ex_stall,
   input  logic                      id_valid,
   input  logic [DATA_WIDTH-1:0]     id_pc_plus4,
   input  logic [DATA_WIDTH-1:0]     id_rs_data,
   input  logic [DATA_WIDTH-1:0]     id_rt_data,
   input  logic [DATA_WIDTH-1:0]     id_imm_ext,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs,
   input  logic [REG_ADDR_WIDTH-1:0] id_rt,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd,
   input  logic [4:0]                id_shamt,
   input  logic                      id_uses_rs,
   input  logic                      id_uses_rt,
   input  logic [ALU_OP_WIDTH-1:0]   id_alu_op,
   input  logic                      id_alu_src,
   input  logic                      id_reg_dst,
   input  logic                      id_reg_write,
   input  logic                      id_mem_read,
   input  logic                      id_mem_write,
   input  logic                      id_mem_to_reg,
   output logic [DATA_WIDTH-1:0]     ex_pc_plus4,
   output logic [DATA_WIDTH-1:0]     ex_rs_data,
   output logic [DATA_WIDTH-1:0]     ex_rt_data,
   output logic [DATA_WIDTH-1:0]     ex_imm_ext,
   output logic [REG_ADDR_WIDTH-1:0] ex_rs,
   output logic [REG_ADDR_WIDTH-1:0] ex_rt,
   output logic [REG_ADDR_WIDTH-1:0] ex_rd,
   output logic [4:0]                ex_shamt,
   output logic [ALU_OP_WIDTH-1:0]   ex_alu_op,
   output logic                      ex_alu_src,
   output logic                      ex_reg_dst,
   output logic                      ex_reg_write,
   output logic                      ex_mem_read,
   output logic                      ex_mem_write,
   output logic                      ex_mem_to_reg,
   output logic                      ex_valid,
   output logic                      load_use_stall,
   output logic [CNT_WIDTH-1:0]      bubble_count
);
   import id_ex_register_pkg::*;

   typedef struct packed {
      logic                      valid;
      logic [DATA_WIDTH-1:0]     pc_plus4;
      logic [DATA_WIDTH-1:0]     rs_data;
      logic [DATA_WIDTH-1:0]     rt_data;
      logic [DATA_WIDTH-1:0]     imm_ext;
      logic [REG_ADDR_WIDTH-1:0] rs;
      logic [REG_ADDR_WIDTH-1:0] rt;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [4:0]                shamt;
      logic [ALU_OP_WIDTH-1:0]   alu_op;
      logic                      alu_src;
      logic                      reg_dst;
      logic                      reg_write;
      logic                      mem_read;
      logic                      mem_write;
      logic                      mem_to_reg;
   } bundle_t;

   bundle_t id_b;
   bundle_t ex_b;
   bundle_t bubble_b;
   logic    hazard;

   always_comb begin
      id_b            = '0;
      id_b.valid      = id_valid;
      id_b.pc_plus4   = id_pc_plus4;
      id_b.rs_data    = id_rs_data;
      id_b.rt_data    = id_rt_data;
      id_b.imm_ext    = id_imm_ext;
      id_b.rs         = id_rs;
      id_b.rt         = id_rt;
      id_b.rd         = id_rd;
      id_b.shamt      = id_shamt;
      id_b.alu_op     = id_alu_op;
      id_b.alu_src    = id_alu_src;
      id_b.reg_dst    = id_reg_dst;
      id_b.reg_write  = id_reg_write;
      id_b.mem_read   = id_mem_read;
      id_b.mem_write  = id_mem_write;
      id_b.mem_to_reg = id_mem_to_reg;
   end

   // Bubbles clear data fields too so EX sees a fully deterministic NOP.
   always_comb begin
      bubble_b        = '0;
      bubble_b.alu_op = ALU_OP_WIDTH'(ALU_OP_NOP);
   end

   load_use_detector #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_detector (
      .ex_valid    (ex_b.valid),
      .ex_mem_read (ex_b.mem_read),
      .ex_rt       (ex_b.rt),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rs  (id_uses_rs),
      .id_uses_rt  (id_uses_rt),
      .hazard      (hazard)
   );

   assign load_use_stall = hazard && !flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_b         <= '0;
         bubble_count <= '0;
      end else if (flush) begin
         ex_b <= bubble_b;
      end else if (!ex_stall) begin
         if (hazard) begin
            ex_b <= bubble_b;
            if (bubble_count != '1)
               bubble_count <= bubble_count + 1'b1;
         end else begin
            ex_b <= id_b;
         end
      end
   end

   assign ex_valid      = ex_b.valid;
   assign ex_pc_plus4   = ex_b.pc_plus4;
   assign ex_rs_data    = ex_b.rs_data;
   assign ex_rt_data    = ex_b.rt_data;
   assign ex_imm_ext    = ex_b.imm_ext;
   assign ex_rs         = ex_b.rs;
   assign ex_rt         = ex_b.rt;
   assign ex_rd         = ex_b.rd;
   assign ex_shamt      = ex_b.shamt;
   assign ex_alu_op     = ex_b.alu_op;
   assign ex_alu_src    = ex_b.alu_src;
   assign ex_reg_dst    = ex_b.reg_dst;
   assign ex_reg_write  = ex_b.reg_write;
   assign ex_mem_read   = ex_b.mem_read;
   assign ex_mem_write  = ex_b.mem_write;
   assign ex_mem_to_reg = ex_b.mem_to_reg;
endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register, bubble counter narrowed to 4 bits to reach saturation quickly.
module tb_id_ex_register;
   localparam int CW = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush, ex_stall, id_valid;
   logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
   logic        id_uses_rs, id_uses_rt;
   logic [3:0]  id_alu_op;
   logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext;
   logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
   logic [3:0]  ex_alu_op;
   logic        ex_alu_src, ex_reg_dst, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic        ex_valid, load_use_stall;
   logic [CW-1:0] bubble_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_ex_register #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .ex_stall(ex_stall), .id_valid(id_valid),
      .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm_ext(id_imm_ext), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_alu_op(id_alu_op),
      .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
      .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
      .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_valid(ex_valid), .load_use_stall(load_use_stall),
      .bubble_count(bubble_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_id();
      flush = 0; ex_stall = 0; id_valid = 0;
      id_pc_plus4 = 0; id_rs_data = 0; id_rt_data = 0; id_imm_ext = 0;
      id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_alu_op = 0; id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
      id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
   endtask

   // Load word: rt is the destination, rs the base register.
   task automatic set_lw(input logic [4:0] rt);
      clear_id();
      id_valid = 1; id_rs = 5'd2; id_rt = rt; id_uses_rs = 1; id_imm_ext = 32'h10;
      id_alu_src = 1; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1; id_alu_op = 4'h2;
   endtask

   task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      clear_id();
      id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rs = 1; id_uses_rt = 1;
      id_reg_dst = 1; id_reg_write = 1; id_alu_op = 4'h1; id_pc_plus4 = 32'h204;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear_id();
      reset_n = 0;
      #3;
      check("rst_valid", ex_valid, 0);
      check("rst_count", bubble_count, 0);
      step();
      reset_n = 1;

      // Asynchronous reset mid-operation
      clear_id();
      id_valid = 1; id_imm_ext = 32'hFFFF_8000; id_reg_write = 1;
      step();
      check("load_imm", ex_imm_ext, 32'hFFFF_8000);
      check("load_rw", ex_reg_write, 1);
      #2 reset_n = 0;
      #1;
      check("arst_imm", ex_imm_ext, 0);
      check("arst_rw", ex_reg_write, 0);
      check("arst_valid", ex_valid, 0);
      check("arst_count", bubble_count, 0);
      #1 reset_n = 1;

      // Normal capture
      clear_id();
      id_valid = 1; id_imm_ext = 32'h0000_1234; id_alu_op = 4'h2; id_rd = 5'd8;
      id_pc_plus4 = 32'h104; id_rs_data = 32'hAAAA_0001; id_rt_data = 32'h5555_0002;
      id_shamt = 5'd3; id_reg_dst = 1; id_reg_write = 1; id_rs = 5'd4; id_rt = 5'd6;
      #1 check("cap_stall", load_use_stall, 0);
      step();
      check("cap_valid", ex_valid, 1);
      check("cap_imm", ex_imm_ext, 32'h0000_1234);
      check("cap_aluop", ex_alu_op, 4'h2);
      check("cap_rd", ex_rd, 8);
      check("cap_pc", ex_pc_plus4, 32'h104);
      check("cap_rsd", ex_rs_data, 32'hAAAA_0001);
      check("cap_rtd", ex_rt_data, 32'h5555_0002);
      check("cap_shamt", ex_shamt, 3);
      check("cap_rt", ex_rt, 6);
      check("cap_stall2", load_use_stall, 0);

      // Load-use through rs: one bubble, then the add is captured
      set_lw(5'd9);
      step();
      check("lw_memrd", ex_mem_read, 1);
      check("lw_rt", ex_rt, 9);
      set_add(5'd9, 5'd3, 5'd10);
      #1 check("lu_stall", load_use_stall, 1);
      step();
      check("lu_bub_valid", ex_valid, 0);
      check("lu_bub_rw", ex_reg_write, 0);
      check("lu_bub_rd", ex_rd, 0);
      check("lu_bub_rs", ex_rs, 0);
      check("lu_count", bubble_count, 1);
      check("lu_stall_off", load_use_stall, 0);
      step();
      check("lu_add_valid", ex_valid, 1);
      check("lu_add_rs", ex_rs, 9);
      check("lu_add_rd", ex_rd, 10);
      check("lu_count2", bubble_count, 1);

      // rt-only dependency; rs match ignored when rs is not used
      set_lw(5'd9);
      step();
      set_add(5'd9, 5'd9, 5'd11);
      id_uses_rs = 0; id_uses_rt = 0;
      #1 check("nouse_stall", load_use_stall, 0);
      id_uses_rt = 1;
      #1 check("rt_stall", load_use_stall, 1);

      // Flush beats stall and hazard
      flush = 1; ex_stall = 1;
      #1 check("flush_stall_out", load_use_stall, 0);
      step();
      check("flush_valid", ex_valid, 0);
      check("flush_memrd", ex_mem_read, 0);
      check("flush_count", bubble_count, 1);

      // Hold a load for 3 stalled cycles with a dependent instruction waiting
      set_lw(5'd12);
      id_pc_plus4 = 32'h300; id_rs_data = 32'hDEAD_BEEF;
      step();
      set_add(5'd12, 5'd1, 5'd13);
      id_rs_data = 32'h1111_1111; id_imm_ext = 32'h7777;
      ex_stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_valid", ex_valid, 1);
         check("hold_memrd", ex_mem_read, 1);
         check("hold_rt", ex_rt, 12);
         check("hold_pc", ex_pc_plus4, 32'h300);
         check("hold_rsd", ex_rs_data, 32'hDEAD_BEEF);
         check("hold_imm", ex_imm_ext, 32'h10);
         check("hold_count", bubble_count, 1);
         check("hold_lus", load_use_stall, 1);
      end
      ex_stall = 0;
      step();
      check("post_hold_valid", ex_valid, 0);
      check("post_hold_count", bubble_count, 2);

      // $0 never triggers a hazard
      set_lw(5'd0);
      step();
      set_add(5'd0, 5'd0, 5'd14);
      #1 check("zero_stall", load_use_stall, 0);
      step();
      check("zero_valid", ex_valid, 1);
      check("zero_rd", ex_rd, 14);
      check("zero_count", bubble_count, 2);

      // Invalid decode slot never triggers a hazard and is captured invalid
      set_lw(5'd9);
      step();
      set_add(5'd9, 5'd9, 5'd15);
      id_valid = 0; id_reg_write = 0; id_reg_dst = 0; id_alu_op = 0;
      #1 check("inv_stall", load_use_stall, 0);
      step();
      check("inv_valid", ex_valid, 0);
      check("inv_rs", ex_rs, 9);
      check("inv_count", bubble_count, 2);

      // Saturation of the 4-bit counter
      for (int i = 0; i < 16; i++) begin
         set_lw(5'd9);
         step();
         set_add(5'd9, 5'd1, 5'd2);
         step();
         check("sat_count", bubble_count, (i + 3 > 15) ? 15 : i + 3);
      end
      check("sat_final", bubble_count, 4'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- Pipeline register between the decode stage and the execute stage.
- Captures the decoded control bundle, the register-file read data and the 32-bit extended immediate produced by the decode stage's immediate extender.
- Inserts bubbles on load-use hazards and on flushes, and holds its contents on execute-stage stalls.
- Also detects load-use hazards and drives the hold request sent upstream to the PC and the IF/ID register.

Parameters:
DATA_WIDTH, 32, width of PC, operand and immediate fields
REG_ADDR_WIDTH, 5, register specifier width
ALU_OP_WIDTH, 4, ALU operation code width
CNT_WIDTH, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  branch/jump resolved in EX; kill the instruction entering EX
ex_stall  in  1  EX/MEM cannot accept; hold all contents
id_valid  in  1  decode stage holds a real instruction
id_pc_plus4  in  DATA_WIDTH  PC+4 of the decode instruction
id_rs_data, id_rt_data  in  DATA_WIDTH  register-file read values
id_imm_ext  in  DATA_WIDTH  extended immediate (zero- or sign-extended upstream)
id_rs, id_rt, id_rd  in  REG_ADDR_WIDTH  register specifiers
id_shamt  in  5  shift amount
id_uses_rs, id_uses_rt  in  1  instruction reads rs / rt
id_alu_op  in  ALU_OP_WIDTH  ALU operation
id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
ex_*  out  (same widths as the id_* bundle above, one ex_ output per id_ input, except id_uses_rs/id_uses_rt)  registered bundle presented to EX
ex_valid  out  1  EX holds a real instruction
load_use_stall  out  1  combinational; hold PC and IF/ID, a bubble is being inserted
bubble_count  out  CNT_WIDTH  saturating count of inserted bubbles

Behaviour:
- Reset (reset_n low, asynchronous): every ex_* output is 0, ex_valid is 0, bubble_count is 0. Reset may assert mid-stall or mid-bubble; on release the first edge behaves as normal capture.
- Hazard detection, combinational: hazard = ex_valid & ex_mem_read & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)) & id_valid.
- load_use_stall = hazard & ~flush. A flush kills the dependent instruction anyway, so no stall is needed.
- Per rising edge, priority is highest first:
  1. flush: insert bubble. This applies even if ex_stall is asserted in the same cycle.
  2. ex_stall: hold every register unchanged; bubble_count unchanged.
  3. hazard: insert bubble and increment bubble_count.
  4. otherwise: capture all id_* into ex_*, with ex_valid <= id_valid.
- Bubble definition:
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src and ex_reg_dst are 0; ex_alu_op is 0.
  - Data and specifier fields (pc, rs/rt data, imm, rs/rt/rd, shamt) are also cleared to 0 so the result is deterministic for verification.
- bubble_count:
  - Increments only on hazard bubbles, not on flush bubbles.
  - Saturates at all-ones and never wraps.
- Latency: exactly 1 cycle from id_* to ex_* when not stalled.
- A load followed by a dependent instruction produces exactly one bubble. The following cycle the hazard term is false because ex_mem_read is then 0, so the dependent instruction captures normally.
- Register $0 never triggers a hazard.
- id_valid = 0 never triggers a hazard and is captured as ex_valid = 0. Its control bits are captured as given; upstream guarantees they are zero.

Decomposition:
- Shared package / header with include guard holds:
  - Width constants DATA_WIDTH, REG_ADDR_WIDTH and ALU_OP_WIDTH.
  - The ALU_OP_NOP = 0 code.
  - Extension-type codes (ZERO = 2'b00, SIGN = 2'b01) so that decode and this block agree.
- One natural sub-module: load_use_detector, purely combinational. Inputs are the EX-side mem_read/rt/valid and the ID-side rs/rt/uses bits/valid; its output is hazard.
- The register and counter logic stay in id_ex_register.

Test Plan:
- Reset mid-operation: load a bundle (id_imm_ext = 32'hFFFF_8000, id_reg_write = 1), then pull reset_n low between edges -> all ex_* and bubble_count are 0 immediately, without waiting for a clock edge.
- Normal capture: id_valid = 1, id_imm_ext = 32'h0000_1234, id_alu_op = 4'h2, id_rd = 5'd8 -> the same values appear on ex_* after one edge, with ex_valid = 1 and load_use_stall = 0.
- Load-use: lw with rt = 5'd9 captured (ex_mem_read = 1), then an add with id_rs = 9 and id_uses_rs = 1:
  - load_use_stall = 1 in that cycle.
  - The next edge produces a bubble (ex_valid = 0, ex_reg_write = 0) and bubble_count = 1.
  - The following edge captures the add.
- $0 immunity: lw with rt = 0, then an instruction with rs = 0 -> no stall, bubble_count stays 0.
- Priority: flush = 1 together with ex_stall = 1 and hazard = 1 -> bubble inserted, load_use_stall = 0, bubble_count unchanged. Then ex_stall alone for 3 cycles -> ex_* is held bit-identical.
- Saturation: force 2^16 + 2 hazard bubbles (or CNT_WIDTH = 4 with 18 bubbles) -> bubble_count ends at all-ones.
